// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter controller: next-PC mode codes
// and a helper that sizes the return-address-stack occupancy counter.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    PC_ADDR_NORMAL = 3'b000,
    PC_ADDR_BRANCH = 3'b001,
    PC_ADDR_JUMP   = 3'b010,
    PC_ADDR_CALL   = 3'b011,
    PC_ADDR_RET    = 3'b100,
    PC_ADDR_EXC    = 3'b101,
    PC_ADDR_ERET   = 3'b110,
    PC_ADDR_RSVD   = 3'b111
  } pc_mode_e;

  // Count must reach RAS_DEPTH itself, so it needs one bit beyond the pointer.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Control/status bundle between the instruction sequencer (master) and
// the PC controller (slave).
interface pc_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic [2:0]        pc_inc_type;
  logic              branch_taken;
  logic [ADDR_W-1:0] abs_addr;
  logic [ADDR_W-1:0] branch_offset;
  logic [ADDR_W-1:0] current_pc;
  logic [ADDR_W-1:0] epc;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_overflow;
  logic              ras_underflow;

  modport master (
    output stall, pc_inc_type, branch_taken, abs_addr, branch_offset,
    input  current_pc, epc, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, pc_inc_type, branch_taken, abs_addr, branch_offset,
    output current_pc, epc, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Updates on the falling edge; pop on an empty stack is ignored.
module pc_ras
  import pc_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_push_data,
  output logic [ADDR_W-1:0] o_top,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = cnt_width(RAS_DEPTH);

  logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_top_idx;

  // r_ptr is the next free slot; when full it also names the oldest entry.
  assign w_top_idx  = r_ptr - PTR_W'(1);
  assign o_top      = r_mem[w_top_idx];
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(RAS_DEPTH));
  assign o_overflow = i_push & o_full;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (!o_full) r_count <= r_count + CNT_W'(1);
    end else if (i_pop && !o_empty) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (i_push) r_mem[r_ptr] <= i_push_data;
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: next-PC mux, PC/EPC registers, sticky RAS flags.
// Single falling-edge update per mode; stall freezes all state.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                RAS_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'('h10)
) (
  input logic       clk,
  input logic       clr,
  pc_ctrl_if.slave  bus
);
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_epc;
  logic              r_ovf;
  logic              r_unf;

  pc_mode_e          w_mode;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_epc_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_unf_set;
  logic              w_push_g;
  logic              w_pop_g;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_empty;
  logic              w_ras_full;
  logic              w_ras_ovf;

  assign w_mode   = pc_mode_e'(bus.pc_inc_type);
  assign w_pc_inc = r_pc + ADDR_W'(1);

  always_comb begin
    w_pc_nxt  = w_pc_inc;
    w_epc_nxt = r_epc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_unf_set = 1'b0;
    case (w_mode)
      PC_ADDR_BRANCH: if (bus.branch_taken) w_pc_nxt = w_pc_inc + bus.branch_offset;
      PC_ADDR_JUMP:   w_pc_nxt = bus.abs_addr;
      PC_ADDR_CALL: begin
        w_push   = 1'b1;
        w_pc_nxt = bus.abs_addr;
      end
      PC_ADDR_RET: begin
        if (!w_ras_empty) begin
          w_pc_nxt = w_ras_top;
          w_pop    = 1'b1;
        end else begin
          w_unf_set = 1'b1;
        end
      end
      PC_ADDR_EXC: begin
        w_epc_nxt = r_pc;
        w_pc_nxt  = EXC_VECTOR;
      end
      PC_ADDR_ERET:   w_pc_nxt = r_epc;
      default:        w_pc_nxt = w_pc_inc;
    endcase
  end

  assign w_push_g = w_push & ~bus.stall;
  assign w_pop_g  = w_pop & ~bus.stall;

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (clr),
    .i_push      (w_push_g),
    .i_pop       (w_pop_g),
    .i_push_data (w_pc_inc),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty),
    .o_full      (w_ras_full),
    .o_overflow  (w_ras_ovf)
  );

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      r_pc  <= RESET_PC;
      r_epc <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!bus.stall) begin
      r_pc  <= w_pc_nxt;
      r_epc <= w_epc_nxt;
      if (w_ras_ovf) r_ovf <= 1'b1;
      if (w_unf_set) r_unf <= 1'b1;
    end
  end

  assign bus.current_pc    = r_pc;
  assign bus.epc           = r_epc;
  assign bus.ras_empty     = w_ras_empty;
  assign bus.ras_full      = w_ras_full;
  assign bus.ras_overflow  = r_ovf;
  assign bus.ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: each issued operation queues its expected state,
// a monitor compares after every falling edge.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        emp;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  logic [31:0] x_epc = '0;
  logic        x_ovf = 1'b0;
  logic        x_unf = 1'b0;

  pc_ctrl_if #(.ADDR_W(32)) bus ();

  pc_ctrl #(
    .ADDR_W     (32),
    .RAS_DEPTH  (8),
    .RESET_PC   (32'h0),
    .EXC_VECTOR (32'h10)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input string nm, input logic [31:0] pc, input logic emp, input logic full);
    exp_t e;
    e.nm = nm; e.pc = pc; e.epc = x_epc; e.emp = emp; e.full = full; e.ovf = x_ovf; e.unf = x_unf;
    q.push_back(e);
  endtask

  task automatic op(input pc_mode_e m, input logic tk, input logic [31:0] abs_a,
                    input logic [31:0] off, input logic st, input logic [31:0] exp_pc,
                    input logic emp, input logic full, input string nm);
    @(posedge clk);
    clr                = 1'b0;
    bus.pc_inc_type    = m;
    bus.branch_taken   = tk;
    bus.abs_addr       = abs_a;
    bus.branch_offset  = off;
    bus.stall          = st;
    push_exp(nm, exp_pc, emp, full);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".pc"},   bus.current_pc, e.pc);
        chk({e.nm, ".epc"},  bus.epc, e.epc);
        chk({e.nm, ".emp"},  32'(bus.ras_empty), 32'(e.emp));
        chk({e.nm, ".full"}, 32'(bus.ras_full), 32'(e.full));
        chk({e.nm, ".ovf"},  32'(bus.ras_overflow), 32'(e.ovf));
        chk({e.nm, ".unf"},  32'(bus.ras_underflow), 32'(e.unf));
      end
    end
  end

  initial begin
    logic [31:0] ret_pc;
    bus.stall = 1'b0; bus.pc_inc_type = PC_ADDR_NORMAL; bus.branch_taken = 1'b0;
    bus.abs_addr = '0; bus.branch_offset = '0;
    push_exp("reset", 32'h0, 1'b1, 1'b0);
    @(negedge clk);

    for (int i = 1; i <= 3; i++) op(PC_ADDR_NORMAL, 0, 0, 0, 0, 32'(i), 1, 0, "normal");

    op(PC_ADDR_JUMP,   0, 32'h5, 0, 0, 32'h5, 1, 0, "jump5");
    op(PC_ADDR_BRANCH, 1, 0, 32'hFFFF_FFFD, 0, 32'h3, 1, 0, "br_taken");
    op(PC_ADDR_JUMP,   0, 32'h5, 0, 0, 32'h5, 1, 0, "jump5b");
    op(PC_ADDR_BRANCH, 0, 0, 32'hFFFF_FFFD, 0, 32'h6, 1, 0, "br_not");
    op(PC_ADDR_JUMP,   0, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 1, 0, "jump_max");
    op(PC_ADDR_NORMAL, 0, 0, 0, 0, 32'h0, 1, 0, "wrap");
    op(PC_ADDR_RSVD,   0, 32'h77, 0, 0, 32'h1, 1, 0, "reserved");

    op(PC_ADDR_JUMP, 0, 32'h2, 0, 0, 32'h2, 1, 0, "jump2");
    op(PC_ADDR_CALL, 0, 32'h100, 0, 0, 32'h100, 0, 0, "call1");
    op(PC_ADDR_CALL, 0, 32'h200, 0, 0, 32'h200, 0, 0, "call2");
    op(PC_ADDR_RET,  0, 0, 0, 0, 32'h101, 0, 0, "ret1");
    op(PC_ADDR_RET,  0, 0, 0, 0, 32'h3, 1, 0, "ret2");
    op(PC_ADDR_JUMP, 0, 32'h55, 0, 1, 32'h3, 1, 0, "stall_jump");
    op(PC_ADDR_CALL, 0, 32'h55, 0, 1, 32'h3, 1, 0, "stall_call");

    // Fill the stack past its depth; the first return address (0x1001) is lost.
    op(PC_ADDR_JUMP, 0, 32'h1000, 0, 0, 32'h1000, 1, 0, "jump1000");
    for (int k = 0; k < 9; k++) begin
      if (k == 8) x_ovf = 1'b1;
      op(PC_ADDR_CALL, 0, 32'h2000 + 32'(k) * 32'h10, 0, 0,
         32'h2000 + 32'(k) * 32'h10, 0, (k >= 7), "deep_call");
    end
    for (int k = 8; k >= 1; k--) begin
      ret_pc = 32'h2000 + 32'(k - 1) * 32'h10 + 32'h1;
      op(PC_ADDR_RET, 0, 0, 0, 0, ret_pc, (k == 1), 0, "deep_ret");
    end
    x_unf = 1'b1;
    op(PC_ADDR_RET, 0, 0, 0, 0, 32'h2002, 1, 0, "ret_underflow");

    op(PC_ADDR_JUMP, 0, 32'h40, 0, 0, 32'h40, 1, 0, "jump40");
    x_epc = 32'h40;
    op(PC_ADDR_EXC,    0, 0, 0, 0, 32'h10, 1, 0, "exc");
    op(PC_ADDR_NORMAL, 0, 0, 0, 0, 32'h11, 1, 0, "exc_normal");
    op(PC_ADDR_ERET,   0, 0, 0, 1, 32'h11, 1, 0, "eret_stall");
    op(PC_ADDR_ERET,   0, 0, 0, 0, 32'h40, 1, 0, "eret");

    op(PC_ADDR_CALL, 0, 32'h300, 0, 0, 32'h300, 0, 0, "pre_rst_call1");
    op(PC_ADDR_CALL, 0, 32'h301, 0, 0, 32'h301, 0, 0, "pre_rst_call2");
    op(PC_ADDR_CALL, 0, 32'h302, 0, 0, 32'h302, 0, 0, "pre_rst_call3");

    // Asynchronous clear between falling edges must act before the next edge.
    @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    chk("async_rst.pc",  bus.current_pc, 32'h0);
    chk("async_rst.epc", bus.epc, 32'h0);
    chk("async_rst.emp", 32'(bus.ras_empty), 32'h1);
    chk("async_rst.ovf", 32'(bus.ras_overflow), 32'h0);
    chk("async_rst.unf", 32'(bus.ras_underflow), 32'h0);
    #1;
    clr = 1'b0;
    x_epc = '0; x_ovf = 1'b0; x_unf = 1'b1;
    op(PC_ADDR_RET, 0, 0, 0, 0, 32'h1, 1, 0, "ret_after_rst");

    repeat (2) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32: PC and address width, in word units; low byte bits are never carried.
REQ-002 Parameter RAS_DEPTH, default 8: return-address-stack entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 Parameter EXC_VECTOR, default 'h10: PC value loaded on exception entry.
REQ-005 clk  in  1  sole clock; all state updates on its falling edge.
REQ-006 clr  in  1  reset; asynchronous, active-high.
REQ-007 stall  in  1  hold all state this cycle.
REQ-008 pc_inc_type  in  3  next-PC mode code (REQ-012).
REQ-009 branch_taken  in  1  branch condition result; used only in BRANCH mode.
REQ-010 abs_addr  in  ADDR_W  absolute target for JUMP and CALL.
REQ-011 branch_offset  in  ADDR_W  two's-complement word offset for BRANCH.
REQ-012 current_pc  out  ADDR_W  registered PC.
REQ-013 epc  out  ADDR_W  registered exception return PC.
REQ-014 ras_empty, ras_full  out  1 each  stack status, combinational from the occupancy count.
REQ-015 ras_overflow, ras_underflow  out  1 each  sticky error flags.

Function
REQ-016 Mode codes: 000 NORMAL, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET, 101 EXC, 110 ERET, 111 reserved; reserved behaves as NORMAL.
REQ-017 NORMAL: current_pc <= current_pc+1.
REQ-018 BRANCH: current_pc <= current_pc+1+branch_offset when branch_taken=1, else current_pc+1.
REQ-019 JUMP: current_pc <= abs_addr.
REQ-020 CALL: push current_pc+1 onto the RAS; current_pc <= abs_addr.
REQ-021 RET with stack non-empty: current_pc <= top entry; pop.
REQ-022 RET with stack empty: current_pc <= current_pc+1; ras_underflow <= 1; stack unchanged.
REQ-023 CALL with stack full: overwrite the oldest entry (circular wrap); occupancy stays RAS_DEPTH; ras_overflow <= 1.
REQ-024 EXC: epc <= current_pc; current_pc <= EXC_VECTOR; RAS unchanged.
REQ-025 ERET: current_pc <= epc; epc unchanged.
REQ-026 All additions wrap modulo 2^ADDR_W; no carry or overflow indication.
REQ-027 stall=1: current_pc, epc, RAS, and flags hold, whatever the mode.
REQ-028 Update latency: exactly one falling edge; no mode needs more than one cycle.
REQ-029 Sticky flags clear only on reset.
REQ-030 RAS holds an occupancy count of 0..RAS_DEPTH and a top pointer that wraps.
REQ-031 ras_empty = (count==0); ras_full = (count==RAS_DEPTH).

Reset
REQ-032 clr=1 asynchronously forces: current_pc=RESET_PC, epc=0, count=0, top pointer=0, both sticky flags=0.
REQ-033 RAS entry contents are not reset.
REQ-034 clr has priority over stall and every mode.
REQ-035 A reset in mid-sequence (for example between CALL and RET) leaves the stack empty; a following RET takes the underflow path.

Structure
REQ-036 Mode codes PC_ADDR_NORMAL, PC_ADDR_BRANCH, PC_ADDR_JUMP, PC_ADDR_CALL, PC_ADDR_RET, PC_ADDR_EXC, PC_ADDR_ERET live in defines.vh, widened to 3 bits.
REQ-037 The RAS is one sub-module, pc_ras, with push, pop, push_data, top, empty, full and overflow-on-push, parameterised by ADDR_W and RAS_DEPTH.
REQ-038 pc_ctrl holds the next-PC mux, the PC register, epc and the sticky flags.

Verification
REQ-039 Reset then NORMAL for 3 cycles -> current_pc 0,1,2,3; ras_empty=1.
REQ-040 At pc=5, BRANCH with offset -3 and taken=1 -> pc=3; same with taken=0 -> pc=6; pc='hFFFFFFFF then NORMAL -> pc=0 (wrap).
REQ-041 Nested calls: CALL abs 'h100 at pc=2, CALL 'h200 at pc='h100, then RET, RET -> pc 'h100, 'h200, 'h101, 3; ras_empty=1 at the end.
REQ-042 RAS_DEPTH=8: 9 CALLs, then 9 RETs -> ras_overflow=1 after the 9th CALL; the first 8 RETs return in LIFO order; the 9th RET falls through as pc+1 and sets ras_underflow=1.
REQ-043 EXC at pc='h40 -> pc='h10, epc='h40; NORMAL then ERET -> pc='h40; stall=1 during ERET -> pc holds at 'h11.
REQ-044 clr asserted between falling edges with count=3 -> current_pc=0 immediately, before the next edge; count=0; following RET -> underflow path.
